// File: rtl/volcado_banco.sv
// volcado_banco: streams every register of a bank over a valid/ready port and keeps a running checksum
module volcado_banco #(
  parameter int WIDTH = 64,
  parameter int NUMREG = 8,
  localparam int INDEX_SIZE = $clog2(NUMREG)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inicio_i,
  output logic [INDEX_SIZE-1:0] A_o,
  input  logic [WIDTH-1:0]      RegA_i,
  output logic [WIDTH-1:0]      dato_o,
  output logic [INDEX_SIZE-1:0] id_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WIDTH-1:0]      suma_o,
  output logic                  ocupado_o,
  output logic                  fin_o
);
  typedef enum logic [1:0] {REPOSO, LEER, ENVIAR, FIN} estado_t;
  estado_t estado_q, estado_d;
  logic [INDEX_SIZE-1:0] idx_q, idx_d, id_q, id_d;
  logic [WIDTH-1:0] dato_q, dato_d, suma_q, suma_d;
  logic ultimo;
  assign ultimo = idx_q == INDEX_SIZE'(NUMREG - 1);
  // next state: read one register, hold it until accepted, then advance or finish
  always_comb begin
    estado_d = estado_q;
    idx_d = idx_q;
    id_d = id_q;
    dato_d = dato_q;
    suma_d = suma_q;
    case (estado_q)
      REPOSO: if (inicio_i) begin
        idx_d = '0;
        suma_d = '0;
        estado_d = LEER;
      end
      LEER: begin
        dato_d = RegA_i;
        id_d = idx_q;
        estado_d = ENVIAR;
      end
      ENVIAR: if (ready_i) begin
        suma_d = suma_q + dato_q;
        estado_d = ultimo ? FIN : LEER;
        idx_d = ultimo ? idx_q : idx_q + 1'b1;
      end
      default: estado_d = REPOSO;
    endcase
  end
  // state registers with synchronous reset taking priority over everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_q <= REPOSO;
      idx_q <= '0;
      id_q <= '0;
      dato_q <= '0;
      suma_q <= '0;
    end else begin
      estado_q <= estado_d;
      idx_q <= idx_d;
      id_q <= id_d;
      dato_q <= dato_d;
      suma_q <= suma_d;
    end
  end
  assign A_o = (estado_q == LEER || estado_q == ENVIAR) ? idx_q : '0;
  assign dato_o = dato_q;
  assign id_o = id_q;
  assign suma_o = suma_q;
  assign valid_o = estado_q == ENVIAR;
  assign fin_o = estado_q == FIN;
  assign ocupado_o = estado_q != REPOSO;
endmodule

// File: tb/tb_volcado_banco.sv
// tb_volcado_banco: randomized dumps checked against a transaction-level model of the bank stream
module tb_volcado_banco;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, inicio, ready;
  logic [2:0] a_o, id, a8, id8;
  logic [63:0] rega, dato, suma;
  logic [7:0] rega8, dato8, suma8;
  logic valid, ocupado, fin, valid8, ocupado8, fin8;
  logic [63:0] bank [8];
  logic [7:0] bank8 [8];
  int checks = 0, failures = 0;
  assign rega = bank[a_o];
  assign rega8 = bank8[a8];
  volcado_banco dut (
    .clk_i(clk), .rst_i(rst), .inicio_i(inicio), .A_o(a_o), .RegA_i(rega),
    .dato_o(dato), .id_o(id), .valid_o(valid), .ready_i(ready),
    .suma_o(suma), .ocupado_o(ocupado), .fin_o(fin)
  );
  volcado_banco #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .inicio_i(inicio), .A_o(a8), .RegA_i(rega8),
    .dato_o(dato8), .id_o(id8), .valid_o(valid8), .ready_i(ready),
    .suma_o(suma8), .ocupado_o(ocupado8), .fin_o(fin8)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // mode 0: ready always 1, 1: random ready, 2: five-cycle stall on id 3
  task automatic dump(input int mode, input bit hold, input int abort_at);
    logic [63:0] sum;
    logic [7:0] sum8;
    int wait_n;
    sum = '0;
    sum8 = '0;
    inicio = 1'b1;
    step;
    inicio = hold;
    for (int k = 0; k < 8; k++) begin
      chk("leer_valid", valid, 0);
      chk("leer_a", a_o, k);
      chk("leer_busy", ocupado, 1);
      chk("leer_fin", fin, 0);
      ready = 1'($urandom_range(0, 1));
      step;
      wait_n = 0;
      forever begin
        chk("env_valid", valid, 1);
        chk("env_id", id, k);
        chk("env_dato", dato, bank[k]);
        chk("env_suma", suma, sum);
        chk("env_a", a_o, k);
        chk("env_busy", ocupado, 1);
        chk("env_fin", fin, 0);
        if (k == abort_at) begin
          rst = 1'b1;
          ready = 1'b1;
          step;
          rst = 1'b0;
          ready = 1'b0;
          chk("rst_valid", valid, 0);
          chk("rst_busy", ocupado, 0);
          chk("rst_suma", suma, 0);
          chk("rst_dato", dato, 0);
          chk("rst_id", id, 0);
          chk("rst_fin", fin, 0);
          return;
        end
        ready = mode == 0 ? 1'b1 : mode == 2 ? (k != 3 || wait_n >= 5) : ($urandom_range(0, 3) != 0);
        step;
        if (ready) break;
        wait_n++;
        if (wait_n > 40) begin
          chk("timeout", wait_n, 0);
          return;
        end
      end
      if (mode == 2 && k == 3) chk("stall_len", wait_n, 5);
      sum += bank[k];
      sum8 += bank8[k];
    end
    ready = 1'($urandom_range(0, 1));
    chk("fin_pulse", fin, 1);
    chk("fin_valid", valid, 0);
    chk("fin_busy", ocupado, 1);
    chk("fin_a", a_o, 0);
    chk("fin_suma", suma, sum);
    step;
    chk("idle_fin", fin, 0);
    chk("idle_busy", ocupado, 0);
    chk("idle_valid", valid, 0);
    chk("idle_suma", suma, sum);
    chk("idle_suma8", suma8, sum8);
    chk("idle_dato", dato, bank[7]);
    chk("idle_id", id, 7);
    chk("idle_a", a_o, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    inicio = 1'b0;
    ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bank[k] = 64'(k + 1);
      bank8[k] = 8'(k + 1);
    end
    step;
    step;
    chk("r_valid", valid, 0);
    chk("r_busy", ocupado, 0);
    chk("r_fin", fin, 0);
    chk("r_suma", suma, 0);
    chk("r_dato", dato, 0);
    chk("r_id", id, 0);
    chk("r_a", a_o, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ready = 1'($urandom_range(0, 1));
      step;
      chk("i_valid", valid, 0);
      chk("i_busy", ocupado, 0);
      chk("i_a", a_o, 0);
    end
    dump(0, 1'b0, -1);
    chk("sum36", suma, 36);
    dump(2, 1'b0, -1);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        bank[k] = {$urandom, $urandom};
        bank8[k] = 8'($urandom);
      end
      dump(1, 1'b0, -1);
    end
    for (int k = 0; k < 8; k++) bank8[k] = 8'hFF;
    dump(1, 1'b0, -1);
    chk("wrap8", suma8, 8'hF8);
    dump(1, 1'b0, 4);
    dump(1, 1'b0, -1);
    dump(0, 1'b1, -1);
    dump(0, 1'b0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
